// File: rtl/toy_lsu_mem_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : toy_lsu_mem_sched_if
// Brief    : LDQ/STQ request, memory request and load-ack signals of the
//            LSU memory scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface toy_lsu_mem_sched_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 256,
    parameter int SB_WIDTH      = 10,
    parameter int MAX_LD_OUTSTD = 8
);
    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_CNT_W  = $clog2(MAX_LD_OUTSTD + 1);

    logic                  ld_req_vld;
    logic                  ld_req_rdy;
    logic [ADDR_WIDTH-1:0] ld_req_addr;
    logic [SB_WIDTH-1:0]   ld_req_sideband;

    logic                  st_req_vld;
    logic                  st_req_rdy;
    logic [ADDR_WIDTH-1:0] st_req_addr;
    logic [DATA_WIDTH-1:0] st_req_data;
    logic [c_STRB_W-1:0]   st_req_strb;
    logic [SB_WIDTH-1:0]   st_req_sideband;

    logic                  mem_req_vld;
    logic                  mem_req_rdy;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic [c_STRB_W-1:0]   mem_req_strb;
    logic                  mem_req_opcode;
    logic [SB_WIDTH-1:0]   mem_req_sideband;

    logic                  mem_ack_vld;
    logic                  mem_ack_rdy;
    logic [c_CNT_W-1:0]    ld_outstd_cnt;

    modport slave (
        input  ld_req_vld, ld_req_addr, ld_req_sideband,
        input  st_req_vld, st_req_addr, st_req_data, st_req_strb, st_req_sideband,
        input  mem_req_rdy, mem_ack_vld, mem_ack_rdy,
        output ld_req_rdy, st_req_rdy,
        output mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb,
        output mem_req_opcode, mem_req_sideband, ld_outstd_cnt
    );

    modport master (
        output ld_req_vld, ld_req_addr, ld_req_sideband,
        output st_req_vld, st_req_addr, st_req_data, st_req_strb, st_req_sideband,
        output mem_req_rdy, mem_ack_vld, mem_ack_rdy,
        input  ld_req_rdy, st_req_rdy,
        input  mem_req_vld, mem_req_addr, mem_req_data, mem_req_strb,
        input  mem_req_opcode, mem_req_sideband, ld_outstd_cnt
    );
endinterface
`default_nettype wire

// File: rtl/toy_lsu_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : toy_lsu_mem_sched
// Brief    : Load-priority arbiter with store starvation limit and load
//            in-flight cap, feeding a single registered memory request port.
// Revision : 1.0 - initial release
// ============================================================================
module toy_lsu_mem_sched #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 256,
    parameter int SB_WIDTH      = 10,
    parameter int LD_BURST      = 4,
    parameter int MAX_LD_OUTSTD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    toy_lsu_mem_sched_if.slave   bus
);
    localparam int c_STRB_W  = DATA_WIDTH / 8;
    localparam int c_CNT_W   = $clog2(MAX_LD_OUTSTD + 1);
    localparam int c_BURST_W = $clog2(LD_BURST + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX   = c_CNT_W'(MAX_LD_OUTSTD);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(LD_BURST);
    localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);

    logic                  r_vld;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [c_STRB_W-1:0]   r_strb;
    logic                  r_op;
    logic [SB_WIDTH-1:0]   r_sb;
    logic [c_BURST_W-1:0]  r_burst;
    logic [c_CNT_W-1:0]    r_outstd;

    logic w_slot_free;
    logic w_ld_ok;
    logic w_st_pri;
    logic w_ld_grant;
    logic w_st_grant;
    logic w_ack;

    // rst_n gates the slot so neither queue sees a grant while reset is held
    assign w_slot_free = rst_n && (!r_vld || bus.mem_req_rdy);
    assign w_ld_ok     = bus.ld_req_vld && (r_outstd < c_CNT_MAX);
    assign w_st_pri    = bus.st_req_vld && ((r_burst == c_BURST_MAX) || !w_ld_ok);
    assign w_st_grant  = w_slot_free && w_st_pri;
    assign w_ld_grant  = w_slot_free && w_ld_ok && !w_st_pri;
    assign w_ack       = bus.mem_ack_vld && bus.mem_ack_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_op     <= 1'b0;
            r_sb     <= '0;
            r_burst  <= '0;
            r_outstd <= '0;
        end else begin
            if (w_slot_free) begin
                r_vld <= w_ld_grant || w_st_grant;
                if (w_st_grant) begin
                    r_addr <= bus.st_req_addr;
                    r_data <= bus.st_req_data;
                    r_strb <= bus.st_req_strb;
                    r_op   <= 1'b1;
                    r_sb   <= bus.st_req_sideband;
                end else if (w_ld_grant) begin
                    r_addr <= bus.ld_req_addr;
                    r_data <= '0;
                    r_strb <= '0;
                    r_op   <= 1'b0;
                    r_sb   <= bus.ld_req_sideband;
                end
            end

            if (!bus.st_req_vld || w_st_grant) begin
                r_burst <= '0;
            end else if (w_ld_grant && (r_burst != c_BURST_MAX)) begin
                r_burst <= r_burst + c_BURST_ONE;
            end

            // an ack against an empty count is dropped so the counter cannot wrap
            if (w_ld_grant && !(w_ack && (r_outstd != '0))) begin
                r_outstd <= r_outstd + c_CNT_ONE;
            end else if (!w_ld_grant && w_ack && (r_outstd != '0)) begin
                r_outstd <= r_outstd - c_CNT_ONE;
            end
        end
    end

    assign bus.ld_req_rdy       = w_ld_grant;
    assign bus.st_req_rdy       = w_st_grant;
    assign bus.mem_req_vld      = r_vld;
    assign bus.mem_req_addr     = r_addr;
    assign bus.mem_req_data     = r_data;
    assign bus.mem_req_strb     = r_strb;
    assign bus.mem_req_opcode   = r_op;
    assign bus.mem_req_sideband = r_sb;
    assign bus.ld_outstd_cnt    = r_outstd;

    a_no_ack_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.mem_ack_vld && bus.mem_ack_rdy && (r_outstd == '0)));

endmodule
`default_nettype wire

// File: tb/tb_toy_lsu_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_toy_lsu_mem_sched
// Brief    : Self-checking bench: directed table, corner sequences and random
//            traffic against a transaction-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_lsu_mem_sched;
    localparam int c_AW    = 32;
    localparam int c_DW    = 256;
    localparam int c_SBW   = 10;
    localparam int c_BURST = 4;
    localparam int c_MAXO  = 8;

    typedef struct packed {
        logic [c_AW-1:0]    addr;
        logic [c_DW-1:0]    data;
        logic [c_DW/8-1:0]  strb;
        logic               op;
        logic [c_SBW-1:0]   sb;
    } req_t;

    typedef struct {
        logic lv;
        logic sv;
        logic ack;
        logic e_ld;
        logic e_st;
        int   e_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic m_vld;
    req_t m_req;
    int   m_cnt;
    int   m_streak;

    toy_lsu_mem_sched_if #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .SB_WIDTH(c_SBW), .MAX_LD_OUTSTD(c_MAXO)
    ) bus ();

    toy_lsu_mem_sched #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .SB_WIDTH(c_SBW),
        .LD_BURST(c_BURST), .MAX_LD_OUTSTD(c_MAXO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_vld    = 1'b0;
        m_req    = '0;
        m_cnt    = 0;
        m_streak = 0;
    endtask

    // One clock: drive at the falling edge, compare just after, advance the model.
    task automatic cycle(input logic lv, input logic sv, input logic mr, input logic av, input logic ar);
        logic free, ld_ok, st_pri, st_g, ld_g;
        @(negedge clk);
        bus.ld_req_vld      = lv;
        bus.st_req_vld      = sv;
        bus.mem_req_rdy     = mr;
        bus.mem_ack_vld     = av;
        bus.mem_ack_rdy     = ar;
        bus.ld_req_addr     = $urandom();
        bus.ld_req_sideband = c_SBW'($urandom());
        bus.st_req_addr     = $urandom();
        bus.st_req_strb     = $urandom();
        bus.st_req_sideband = c_SBW'($urandom());
        for (int k = 0; k < c_DW / 32; k++) bus.st_req_data[k*32 +: 32] = $urandom();
        #1;
        free   = !m_vld || mr;
        ld_ok  = lv && (m_cnt < c_MAXO);
        st_pri = sv && ((m_streak >= c_BURST) || !ld_ok);
        st_g   = free && st_pri;
        ld_g   = free && ld_ok && !st_pri;

        check("ld_req_rdy", bus.ld_req_rdy, ld_g);
        check("st_req_rdy", bus.st_req_rdy, st_g);
        check("mem_req_vld", bus.mem_req_vld, m_vld);
        check("ld_outstd_cnt", bus.ld_outstd_cnt, m_cnt);
        if (m_vld) begin
            check("mem_req_addr", bus.mem_req_addr, m_req.addr);
            check("mem_req_data", bus.mem_req_data, m_req.data);
            check("mem_req_strb", bus.mem_req_strb, m_req.strb);
            check("mem_req_opcode", bus.mem_req_opcode, m_req.op);
            check("mem_req_sideband", bus.mem_req_sideband, m_req.sb);
        end

        if (free) begin
            m_vld = st_g || ld_g;
            if (st_g)
                m_req = '{bus.st_req_addr, bus.st_req_data, bus.st_req_strb, 1'b1, bus.st_req_sideband};
            else if (ld_g)
                m_req = '{bus.ld_req_addr, '0, '0, 1'b0, bus.ld_req_sideband};
        end
        if (!sv || st_g)                       m_streak = 0;
        else if (ld_g && m_streak < c_BURST)   m_streak = m_streak + 1;
        m_cnt = m_cnt + (ld_g ? 1 : 0) - ((av && ar && m_cnt > 0) ? 1 : 0);
    endtask

    // Asserts reset asynchronously (between edges) and checks it takes effect at once.
    task automatic apply_reset();
        rst_n           = 1'b0;
        bus.ld_req_vld  = 1'b1;
        bus.st_req_vld  = 1'b1;
        bus.mem_req_rdy = 1'b1;
        bus.mem_ack_vld = 1'b0;
        bus.mem_ack_rdy = 1'b0;
        #1;
        check("rst_mem_req_vld", bus.mem_req_vld, 1'b0);
        check("rst_ld_req_rdy", bus.ld_req_rdy, 1'b0);
        check("rst_st_req_rdy", bus.st_req_rdy, 1'b0);
        check("rst_outstd_cnt", bus.ld_outstd_cnt, 0);
        model_clear();
        repeat (2) @(negedge clk);
        bus.ld_req_vld = 1'b0;
        bus.st_req_vld = 1'b0;
        rst_n          = 1'b1;
    endtask

    vec_t tbl[14];
    logic [c_AW-1:0] saved_addr;

    initial begin
        checks   = 0;
        failures = 0;
        model_clear();
        bus.ld_req_addr     = '0;
        bus.ld_req_sideband = '0;
        bus.st_req_addr     = '0;
        bus.st_req_data     = '0;
        bus.st_req_strb     = '0;
        bus.st_req_sideband = '0;

        // both queues busy, no backpressure: L,L,L,L,S repeating, then ld/st drop-outs
        tbl[0]  = '{1, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 0, 1};
        tbl[2]  = '{1, 1, 1, 1, 0, 1};
        tbl[3]  = '{1, 1, 1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 1, 1};
        tbl[5]  = '{1, 1, 0, 1, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 0, 1};
        tbl[7]  = '{1, 1, 1, 1, 0, 1};
        tbl[8]  = '{1, 1, 1, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 0, 1, 1};
        tbl[10] = '{0, 1, 0, 0, 1, 0};
        tbl[11] = '{1, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 1, 1, 1, 0, 1};
        tbl[13] = '{0, 0, 1, 0, 0, 1};

        #2;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].lv, tbl[i].sv, 1'b1, tbl[i].ack, tbl[i].ack);
            check($sformatf("tbl%0d_ld_rdy", i), bus.ld_req_rdy, tbl[i].e_ld);
            check($sformatf("tbl%0d_st_rdy", i), bus.st_req_rdy, tbl[i].e_st);
            check($sformatf("tbl%0d_cnt", i), bus.ld_outstd_cnt, tbl[i].e_cnt);
            if (i > 0) begin
                check($sformatf("tbl%0d_vld", i), bus.mem_req_vld, tbl[i-1].e_ld | tbl[i-1].e_st);
                if (tbl[i-1].e_ld | tbl[i-1].e_st)
                    check($sformatf("tbl%0d_op", i), bus.mem_req_opcode, tbl[i-1].e_st);
            end
        end

        // loads only, acks two cycles after grant
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b1, i >= 2, i >= 2);
            check("l_only_ld_rdy", bus.ld_req_rdy, 1'b1);
            check("l_only_cnt_le2", bus.ld_outstd_cnt <= 2, 1'b1);
            if (i > 0) check("l_only_op", bus.mem_req_opcode, 1'b0);
        end

        // in-flight cap reached: loads held, stores flow, one ack frees a slot
        apply_reset();
        repeat (c_MAXO) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check("cap_cnt", bus.ld_outstd_cnt, c_MAXO);
            check("cap_ld_held", bus.ld_req_rdy, 1'b0);
            check("cap_st_flows", bus.st_req_rdy, 1'b1);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("cap_ack_ld_held", bus.ld_req_rdy, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cap_after_ack_cnt", bus.ld_outstd_cnt, c_MAXO - 1);
        check("cap_after_ack_ld", bus.ld_req_rdy, 1'b1);

        // backpressure holds a registered store
        apply_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        saved_addr = bus.st_req_addr;
        repeat (5) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            check("bp_vld", bus.mem_req_vld, 1'b1);
            check("bp_op", bus.mem_req_opcode, 1'b1);
            check("bp_addr", bus.mem_req_addr, saved_addr);
            check("bp_ld_rdy", bus.ld_req_rdy, 1'b0);
            check("bp_st_rdy", bus.st_req_rdy, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bp_release_ld_rdy", bus.ld_req_rdy, 1'b1);
        saved_addr = bus.ld_req_addr;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bp_next_op", bus.mem_req_opcode, 1'b0);
        check("bp_next_addr", bus.mem_req_addr, saved_addr);

        // grant and ack together leave the count alone
        apply_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("same_cyc_ld_rdy", bus.ld_req_rdy, 1'b1);
        check("same_cyc_cnt_before", bus.ld_outstd_cnt, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("same_cyc_cnt_after", bus.ld_outstd_cnt, 3);

        // reset while a request is pending
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_vld", bus.mem_req_vld, 1'b1);
        apply_reset();
        repeat (2) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check("post_rst_vld", bus.mem_req_vld, 1'b0);
        end

        // random traffic against the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            logic av, ar;
            av = $urandom_range(0, 2) == 0;
            ar = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0, av, ar);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
